// File: rtl/dma_defs.sv
// Shared DMA definitions: FSM state encodings used by every bus master.
package dma_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } dma_state_e;

  // Byte stride between consecutive words.
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dma_copy.sv
// Word-by-word memory-to-memory copy engine with running checksum.
// One word per READ/WRITE pair; RAM read data is combinational.
module dma_copy
  import dma_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int BITS  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BITS-1:0]  src_adr,
  input  logic [BITS-1:0]  dst_adr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] checksum,
  output logic             mem_we,
  output logic [BITS-1:0]  mem_adr,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);

  dma_state_e       state_q, state_d;
  logic [BITS-1:0]  src_q, src_d;
  logic [BITS-1:0]  dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] csum_q, csum_d;

  assign checksum = csum_q;

  // State and datapath registers; reset wins over everything, including mid-copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      csum_q  <= csum_d;
    end
  end

  // Next-state and memory-port decode; outputs are zero outside READ/WRITE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    csum_d  = csum_q;
    busy    = 1'b0;
    done    = 1'b0;
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_din = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          csum_d = '0;
          if (count != '0) begin
            src_d   = src_adr;
            dst_d   = dst_adr;
            cnt_d   = count;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        busy    = 1'b1;
        mem_adr = src_q;
        buf_d   = mem_dout;
        csum_d  = csum_q + mem_dout;
        state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        mem_adr = dst_q;
        mem_din = buf_q;
        // Pointers wrap naturally at 2^BITS; low address bits ride along untouched.
        src_d   = src_q + BITS'(WORD_BYTES);
        dst_d   = dst_q + BITS'(WORD_BYTES);
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: 128-word RAM, reference memory model and
// a queue of expected writes checked as the DUT issues them.
module tb_dma_copy;
  import dma_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_adr, dst_adr;
  logic [7:0]  count;
  logic        busy, done, mem_we;
  logic [31:0] checksum, mem_adr, mem_din, mem_dout;

  logic [31:0] ram     [128];
  logic [31:0] ref_mem [128];
  logic [63:0] wq [$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_copy #(.WIDTH(32), .BITS(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_adr(src_adr), .dst_adr(dst_adr), .count(count),
    .busy(busy), .done(done), .checksum(checksum),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // RAM: combinational read, write on the rising edge; address bits [1:0] ignored.
  assign mem_dout = ram[mem_adr[8:2]];
  always @(posedge clk) if (mem_we) ram[mem_adr[8:2]] <= mem_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    ram[idx]     = v;
    ref_mem[idx] = v;
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 128; i++) chk(tag, ram[i], ref_mem[i]);
  endtask

  // Run one copy. model_words: how many words the reference copies (less than
  // cnt when reset aborts). rst_cyc: cycle index in which reset is raised (-1 none).
  task automatic run(input string tag, input logic [31:0] src, input logic [31:0] dst,
                     input int cnt, input int model_words, input int rst_cyc, input bit inj);
    logic [31:0] csum, sa, da, d, e_adr, e_dat;
    logic [63:0] e;
    int cyc, rd;
    bit fin;
    csum = 0;
    for (int i = 0; i < model_words; i++) begin
      sa = src + 32'(4*i);
      da = dst + 32'(4*i);
      d  = ref_mem[sa[8:2]];
      wq.push_back({da, d});
      ref_mem[da[8:2]] = d;
      csum += d;
    end
    start = 1'b1; src_adr = src; dst_adr = dst; count = 8'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    src_adr = $urandom; dst_adr = $urandom; count = 8'($urandom_range(1, 200));
    cyc = 1; rd = 0; fin = 0;
    while (!fin && cyc < 4*cnt + 10) begin
      if (inj && cyc == 3) begin
        start = 1'b1; src_adr = 32'h0000_0100; dst_adr = 32'h0000_0180; count = 8'd5;
      end
      if (inj && cyc == 4) start = 1'b0;
      chk({tag, "_busy_done_excl"}, 32'(busy & done), 32'd0);
      if (mem_we) begin
        if (wq.size() == 0) chk({tag, "_unexpected_write"}, mem_adr, 32'hFFFF_FFFF);
        else begin
          e = wq.pop_front();
          e_adr = e[63:32]; e_dat = e[31:0];
          chk({tag, "_wr_adr"}, mem_adr, e_adr);
          chk({tag, "_wr_din"}, mem_din, e_dat);
        end
      end else if (busy) begin
        chk({tag, "_rd_adr"}, mem_adr, src + 32'(4*rd));
        rd++;
      end else begin
        chk({tag, "_idle_adr"}, mem_adr, 32'd0);
        chk({tag, "_idle_din"}, mem_din, 32'd0);
      end
      if (done) begin
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(2*cnt + 1));
        chk({tag, "_checksum"}, checksum, csum);
        fin = 1;
      end
      if (cyc == rst_cyc) reset = 1'b1;
      @(posedge clk); #1;
      if (reset) begin
        reset = 1'b0;
        chk({tag, "_rst_state"}, 32'(dut.state_q), 32'(IDLE));
        chk({tag, "_rst_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rst_adr"}, mem_adr, 32'd0);
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1;
          chk({tag, "_no_write_after_rst"}, 32'(mem_we), 32'd0);
        end
        fin = 1;
      end
      cyc++;
    end
    if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_queue_empty"}, 32'(wq.size()), 32'd0);
    wq.delete();
    if (rst_cyc < 0) begin
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_csum_held"}, checksum, csum);
    end
    chk_mem({tag, "_mem"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_adr = '0; dst_adr = '0; count = '0;
    for (int i = 0; i < 128; i++) preload(i, 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_adr", mem_adr, 32'd0);
    chk("rst_din", mem_din, 32'd0);
    chk("rst_csum", checksum, 32'd0);
    chk("rst_ptrs", dut.src_q | dut.dst_q | 32'(dut.cnt_q) | dut.buf_q, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic copy
    preload(0, 32'h11); preload(1, 32'h22); preload(2, 32'h33); preload(3, 32'h44);
    run("basic", 32'h0, 32'h40, 4, 4, -1, 0);
    chk("basic_csum_const", checksum, 32'hAA);
    chk("basic_w16", ram[16], 32'h11);
    chk("basic_w19", ram[19], 32'h44);

    // Zero count
    run("zero", 32'h0, 32'h80, 0, 0, -1, 0);
    chk("zero_csum_const", checksum, 32'd0);

    // Start pulsed while busy must be ignored
    run("inj", 32'h20, 32'h60, 4, 4, -1, 1);

    // Reset in cycle 5 of an 8-word copy: two words already written
    run("abort", 32'h100, 32'h180, 8, 2, 5, 0);
    chk("abort_csum_cleared", checksum, 32'd0);

    // Overlap: dst = src + 4 replicates the first word
    preload(0, 32'hDEAD_BEEF);
    run("overlap", 32'h0, 32'h4, 3, 3, -1, 0);
    chk("overlap_w1", ram[1], 32'hDEAD_BEEF);
    chk("overlap_w3", ram[3], 32'hDEAD_BEEF);

    // Source pointer wrap: second read address is 0
    run("wrap", 32'hFFFF_FFFC, 32'h100, 2, 2, -1, 0);

    // Low address bits ride along unchanged
    run("lowbits", 32'h0000_0043, 32'h0000_00C1, 2, 2, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; matches the data RAM word width.
REQ-002 Parameter BITS, default 32, byte-address width in bits.
REQ-003 Parameter CNT_W, default 8, width of the word-count input.
REQ-004 clk  input  1  Single clock for all state; all registers update on the rising edge.
REQ-005 reset  input  1  Reset; synchronous and active-high.
REQ-006 start  input  1  Request to begin a copy; sampled only in IDLE.
REQ-007 src_adr  input  BITS  Byte address of the first source word.
REQ-008 dst_adr  input  BITS  Byte address of the first destination word.
REQ-009 count  input  CNT_W  Number of words to copy; 0 is legal.
REQ-010 busy  output  1  High while a copy is in progress (READ or WRITE state).
REQ-011 done  output  1  One-cycle pulse when a copy completes.
REQ-012 checksum  output  WIDTH  Modulo-2^WIDTH sum of all words copied by the last copy.
REQ-013 mem_we  output  1  Write enable to the data RAM.
REQ-014 mem_adr  output  BITS  Byte address to the data RAM.
REQ-015 mem_din  output  WIDTH  Write data to the data RAM.
REQ-016 mem_dout  input  WIDTH  Read data from the data RAM: combinational, valid in the same cycle as mem_adr.

Function
REQ-017 The block SHALL implement the FSM states IDLE, READ, WRITE, DONE.
REQ-018 In IDLE, when start=1 and count!=0, the block SHALL latch src_adr, dst_adr and count, clear checksum, and enter READ.
REQ-019 In IDLE, when start=1 and count=0, the block SHALL clear checksum and enter DONE, with no memory access.
REQ-020 In READ, the block SHALL drive mem_adr=current source pointer and mem_we=0, register mem_dout into a data buffer, add mem_dout to checksum, and enter WRITE.
REQ-021 In WRITE, the block SHALL drive mem_adr=current destination pointer, mem_din=data buffer and mem_we=1.
REQ-022 In WRITE, the block SHALL increment both pointers by 4 and decrement the remaining count.
REQ-023 In WRITE, the block SHALL enter DONE if the remaining count was 1, else READ.
REQ-024 Throughput SHALL be exactly 2 cycles per word; a copy of N>0 words SHALL assert done on cycle 2N+1 after the start cycle.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-026 busy SHALL be 1 only in READ and WRITE; done and busy SHALL never be high together.
REQ-027 mem_we SHALL be 1 only in WRITE.
REQ-028 In IDLE and DONE, mem_adr and mem_din SHALL be 0.
REQ-029 start SHALL be ignored outside IDLE; inputs changing mid-copy SHALL have no effect.
REQ-030 Pointer arithmetic SHALL be modulo 2^BITS (wrap-around, no error).
REQ-031 Address bits [1:0] SHALL be passed through unchanged; the RAM ignores them.
REQ-032 Overlapping regions SHALL be copied in ascending word order with no overlap detection; for dst=src+4 this replicates the first word.
REQ-033 checksum SHALL hold its value from DONE until the next accepted start.

Reset
REQ-034 reset=1 at a clock edge SHALL force IDLE from any state, including mid-copy.
REQ-035 On reset, busy=0, done=0, mem_we=0, mem_adr=0, mem_din=0, checksum=0, and pointers, count and buffer = 0.
REQ-036 An aborted copy SHALL leave already-written words in memory, and no further write SHALL occur.

Structure
REQ-037 State encodings (IDLE=2'b00, READ=2'b01, WRITE=2'b10, DONE=2'b11) SHALL reside in a shared definitions include, dma_defs, shared with future bus masters.
REQ-038 The block SHALL be a single module with no sub-module.
REQ-039 The bench SHALL connect the block to a ram instance of depth 128.

Verification
REQ-040 Basic copy: preload words 0..3 = 0x11,0x22,0x33,0x44; start with src=0x0, dst=0x40, count=4 -> words 16..19 = 0x11..0x44, done on cycle 9, checksum=0xAA.
REQ-041 Zero count: start with count=0 -> done pulses on the next cycle, no mem_we assertion, checksum=0.
REQ-042 Start during copy: pulse start with new addresses while busy -> ignored, and the original copy completes unchanged.
REQ-043 Reset mid-copy: count=8, assert reset in cycle 5 -> state IDLE, mem_we=0 next cycle, only words written before reset are modified.
REQ-044 Overlap and wrap: preload word0=0xDEADBEEF; src=0x0, dst=0x4, count=3 -> words 1..3 = 0xDEADBEEF.
REQ-045 Pointer wrap: src=0xFFFFFFFC, count=2 -> second read address is 0x00000000.
